// File: rtl/acc_pkg.sv
// Shared accelerator definitions: client ids, arbiter state encoding and
// the mod-3 round-robin step used by the memory arbiter.
package acc_pkg;

  localparam logic [1:0] CLI_IMAP = 2'd0;
  localparam logic [1:0] CLI_WT   = 2'd1;
  localparam logic [1:0] CLI_OMAP = 2'd2;
  localparam logic [1:0] CLI_NONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  // Next client in round-robin order; CLI_NONE wraps to imap as well.
  function automatic logic [1:0] cli_next(input logic [1:0] c);
    return (c == CLI_OMAP || c == CLI_NONE) ? CLI_IMAP : c + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: first requester scanning
// from last + 1 (mod 3).
module rr_pick3
  import acc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] req_x;
  logic [1:0] c0, c1, c2;

  always_comb begin
    req_x  = {1'b0, req};
    c0     = cli_next(last);
    c1     = cli_next(c0);
    c2     = cli_next(c1);
    any    = |req;
    winner = CLI_NONE;
    if (req_x[c0]) begin
      winner = c0;
    end else if (req_x[c1]) begin
      winner = c1;
    end else if (req_x[c2]) begin
      winner = c2;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner arbiter for the single external memory port shared by the
// imap/weight read BIUs and the omap write BIU. Optional: MEM_ARB_PERF_EN.
module mem_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OST_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imap_biu2arb_req,
  input  logic              wt_biu2arb_req,
  input  logic              omap_biu2arb_req,
  input  logic [ADDR_W-1:0] imap_biu2arb_addr,
  input  logic [ADDR_W-1:0] wt_biu2arb_addr,
  input  logic [ADDR_W-1:0] omap_biu2arb_addr,
  input  logic [DATA_W-1:0] omap_biu2arb_wdata,
  input  logic              imap_biu2arb_vld,
  input  logic              wt_biu2arb_vld,
  input  logic              omap_biu2arb_vld,
  output logic              imap_biu2arb_rdy,
  output logic              wt_biu2arb_rdy,
  output logic              omap_biu2arb_rdy,
  output logic [DATA_W-1:0] arb2imap_biu_data,
  output logic [DATA_W-1:0] arb2wt_biu_data,
  output logic              arb2imap_biu_vld,
  output logic              arb2wt_biu_vld,
  input  logic              arb2imap_biu_rdy,
  input  logic              arb2wt_biu_rdy,
  output logic              mem_req_vld,
  input  logic              mem_req_rdy,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_vld,
  output logic              mem_rsp_rdy,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [1:0]        grant_id
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_imap_cyc,
  output logic [31:0]       perf_wt_cyc,
  output logic [31:0]       perf_omap_cyc
`endif
);

  localparam logic [OST_W-1:0] OstMax = '1;
  localparam logic [OST_W-1:0] OstOne = {{(OST_W-1){1'b0}}, 1'b1};

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [OST_W-1:0]  ost_q, ost_d;

  logic [1:0]        win;
  logic              any_req;
  logic              own_req, own_vld, own_rsp_rdy, own_rdy;
  logic [ADDR_W-1:0] own_addr;
  logic              rd_owner, stall, busy, req_hs, rsp_hs;

  rr_pick3 u_pick (
    .req    ({omap_biu2arb_req, wt_biu2arb_req, imap_biu2arb_req}),
    .last   (last_q),
    .winner (win),
    .any    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= CLI_NONE;
      last_q  <= CLI_OMAP;
      ost_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ost_q   <= ost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
          owner_d = win;
          last_d  = win;
        end
      end
      // A dropped req with a beat still pending is held until that beat completes.
      StBusy:  if (!own_req && (!own_vld || req_hs)) state_d = StDrain;
      StDrain: begin
        if (ost_q == '0) begin
          state_d = StIdle;
          owner_d = CLI_NONE;
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = CLI_NONE;
      end
    endcase

    ost_d = ost_q;
    if (req_hs && !mem_req_we && !rsp_hs) begin
      ost_d = ost_q + OstOne;
    end else if (rsp_hs && !(req_hs && !mem_req_we)) begin
      ost_d = ost_q - OstOne;
    end
  end

  always_comb begin
    own_req     = 1'b0;
    own_vld     = 1'b0;
    own_addr    = '0;
    own_rsp_rdy = 1'b0;
    case (owner_q)
      CLI_IMAP: begin
        own_req     = imap_biu2arb_req;
        own_vld     = imap_biu2arb_vld;
        own_addr    = imap_biu2arb_addr;
        own_rsp_rdy = arb2imap_biu_rdy;
      end
      CLI_WT: begin
        own_req     = wt_biu2arb_req;
        own_vld     = wt_biu2arb_vld;
        own_addr    = wt_biu2arb_addr;
        own_rsp_rdy = arb2wt_biu_rdy;
      end
      CLI_OMAP: begin
        own_req  = omap_biu2arb_req;
        own_vld  = omap_biu2arb_vld;
        own_addr = omap_biu2arb_addr;
      end
      default: ;
    endcase

    busy     = (state_q == StBusy);
    rd_owner = (owner_q == CLI_IMAP) || (owner_q == CLI_WT);
    stall    = rd_owner && (ost_q == OstMax);

    mem_req_vld   = busy && own_vld && !stall;
    mem_req_addr  = own_addr;
    mem_req_we    = (owner_q == CLI_OMAP);
    mem_req_wdata = omap_biu2arb_wdata;
    own_rdy       = busy && mem_req_rdy && !stall;
    req_hs        = mem_req_vld && mem_req_rdy;

    imap_biu2arb_rdy = own_rdy && (owner_q == CLI_IMAP);
    wt_biu2arb_rdy   = own_rdy && (owner_q == CLI_WT);
    omap_biu2arb_rdy = own_rdy && (owner_q == CLI_OMAP);

    // owner_q stays set through DRAIN, so responses keep their route there.
    mem_rsp_rdy       = rd_owner && own_rsp_rdy;
    rsp_hs            = mem_rsp_vld && mem_rsp_rdy;
    arb2imap_biu_vld  = (owner_q == CLI_IMAP) && mem_rsp_vld;
    arb2wt_biu_vld    = (owner_q == CLI_WT) && mem_rsp_vld;
    arb2imap_biu_data = mem_rsp_data;
    arb2wt_biu_data   = mem_rsp_data;
    grant_id          = owner_q;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_q [3];
  logic [31:0] perf_d [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      perf_d[i] = perf_q[i];
      if (owner_q == 2'(i) && perf_q[i] != '1) perf_d[i] = perf_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) perf_q[i] <= perf_d[i];
    end
  end

  assign perf_imap_cyc = perf_q[0];
  assign perf_wt_cyc   = perf_q[1];
  assign perf_omap_cyc = perf_q[2];
`endif

endmodule
